// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default width
// and the MIPS function codes that select DIV/DIVU.
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } div_state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division step: shift {rem, quo} left and subtract the divisor
// when the shifted partial remainder is large enough.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_abs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // The comparison uses the full WIDTH+1 bit shifted value. The subtraction result
  // fits in WIDTH bits whenever it is kept, so the low half is enough.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor_abs});
    trial    = shifted[WIDTH-1:0] - divisor_abs;
    rem_next = fits ? trial : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/iter_divider.sv
// Multicycle restoring divider for the EX stage: one quotient bit per cycle,
// sign fix on completion, and a stall request that holds the pipeline meanwhile.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  div_state_e state, next_state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, divisor_abs_q;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;

  // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
  assign dividend_abs = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_abs  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_abs (divisor_abs_q),
    .rem_next    (rem_step),
    .quo_next    (quo_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !flush) next_state = S_CALC;
        stall = start && !flush;
      end
      S_CALC: begin
        stall = 1'b1;
        if (flush)                          next_state = S_IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))  next_state = S_FINISH;
      end
      S_FINISH: begin
        stall      = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // A flush in CALC/FINISH leaves q/r untouched and suppresses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_abs_q <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      q             <= '0;
      r             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy <= (next_state != S_IDLE);
      done <= (state == S_FINISH) && !flush;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            quo_q         <= dividend_abs;
            divisor_abs_q <= divisor_abs;
            rem_q         <= '0;
            cnt           <= '0;
            q_neg         <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg         <= sign && dividend[WIDTH-1];
          end
        end
        S_CALC: begin
          if (!flush) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt + 1'b1;
          end
        end
        S_FINISH: begin
          if (!flush) begin
            q <= q_neg ? -quo_q : quo_q;
            r <= r_neg ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
